mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: in_valid  in  1  request valid.
REQ-004 SHALL have: in_ready  out  1  request accepted when in_valid && in_ready.
REQ-005 SHALL have: op  in  3  0=MUL, 1=MULHU, 2=DIV, 3=DIVU, 4=REM, 5=REMU; 6,7 illegal.
REQ-006 SHALL have: src1, src2  in  32  operands (dividend/divisor for div ops).
REQ-007 SHALL have: rd_in  in  5  destination tag; rd_out  out  5  tag returned with result.
REQ-008 SHALL have: out_valid  out  1  result valid.
REQ-009 SHALL have: out_ready  in  1  consumer accepts when out_valid && out_ready.
REQ-010 SHALL have: result  out  32  registered result.
REQ-011 SHALL have: flush  in  1  synchronous abort.
REQ-012 SHALL have: busy  out  1  high whenever state != IDLE.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; in_ready = (state==IDLE) && !flush, combinational.
REQ-014 SHALL on accept latch op, operands, rd_in; clear iteration counter to 0; go IDLE->CALC.
REQ-015 SHALL in CALC perform one iteration per cycle: shift-add multiply (64-bit product, unsigned) or restoring divide (33-bit partial remainder).
REQ-016 SHALL for DIV/REM operate on absolute values and apply sign fix-up when entering DONE: quotient negated if signs differ, remainder takes dividend sign.
REQ-017 SHALL go CALC->DONE on the edge where counter==31 (32 iterations); out_valid rises 33 cycles after the accept cycle.
REQ-018 SHALL drive result: MUL=product[31:0], MULHU=product[63:32], DIV/DIVU=quotient, REM/REMU=remainder.
REQ-019 SHALL on divisor==0: quotient=32'hFFFFFFFF, remainder=src1 (signed and unsigned).
REQ-020 SHALL on DIV/REM with src1=32'h80000000, src2=32'hFFFFFFFF: quotient=32'h80000000, remainder=0.
REQ-021 SHALL treat illegal op as result=0, same latency as MUL.
REQ-022 SHALL hold result, rd_out, out_valid stable in DONE until out_valid && out_ready; then DONE->IDLE; no accept in that same cycle (one-cycle bubble).
REQ-023 SHALL on flush=1 in any state go to IDLE next edge, deassert out_valid, discard work; flush overrides a simultaneous in_valid (no accept).
REQ-024 SHALL ignore in_valid and operand changes outside IDLE.

Reset
REQ-025 SHALL on rst asynchronously force state=IDLE, out_valid=0, busy=0, result=0, rd_out=0, counter=0, all latched operands=0.
REQ-026 SHALL on rst mid-CALC or in DONE drop the pending result with no output handshake after release.
REQ-027 SHALL present in_ready=1 in the first cycle after rst deasserts (flush low).

Configuration
REQ-028 SHALL use macro MDU_EARLY_OUT_EN.
REQ-029 SHALL with MDU_EARLY_OUT_EN defined: MUL/MULHU with either operand 0, and any div op with divisor 0, skip CALC, IDLE->DONE directly, out_valid 1 cycle after accept.
REQ-030 SHALL without MDU_EARLY_OUT_EN: all legal and illegal ops take the full 33-cycle latency; results identical either way.

Verification
REQ-031 SHALL cover: MUL 7 x 6, out_ready=1 -> result=42, out_valid at accept+33, rd_out echoes rd_in.
REQ-032 SHALL cover: MULHU 32'hFFFFFFFF x 32'hFFFFFFFF -> result=32'hFFFFFFFE; DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF.
REQ-033 SHALL cover: DIVU 5/0 -> 32'hFFFFFFFF, REMU 5/0 -> 5; DIV 32'h80000000/-1 -> 32'h80000000; latency 1 or 33 per MDU_EARLY_OUT_EN.
REQ-034 SHALL cover: out_ready held 0 for 10 cycles in DONE -> result/rd_out stable, in_ready=0; in_valid on the release cycle not accepted.
REQ-035 SHALL cover: flush at CALC iteration 15 with in_valid=1 -> IDLE next edge, no accept, no out_valid; next request completes correctly.
REQ-036 SHALL cover: rst asserted mid-CALC between edges -> out_valid=0, busy=0 immediately; no stale result after release.

Source files
------------

// File: rtl/mdu_ctrl.sv
`default_nettype none
// mdu_ctrl: iterative 32-bit multiply/divide unit (shift-add multiply, restoring divide).
// Optional macro MDU_EARLY_OUT_EN: zero-operand multiply and zero-divisor ops finish in one cycle.
module mdu_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic [4:0]  rd_in,
   output logic [4:0]  rd_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   input  logic        flush,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_MUL   = 3'd0;
   localparam logic [2:0] OP_MULHU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_REM   = 3'd4;
   localparam logic [2:0] OP_REMU  = 3'd5;

   state_t      r_state;
   state_t      w_state_nx;
   logic [2:0]  r_op;
   logic [31:0] r_src1;
   logic [31:0] r_b;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [4:0]  r_cnt;
   logic [4:0]  r_rd;
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_dz;
   logic [31:0] r_result;

   logic        w_accept;
   logic        w_in_div;
   logic        w_in_sgn;
   logic [31:0] w_abs1;
   logic [31:0] w_abs2;
   logic        w_early;
   logic [31:0] w_early_res;
   logic        w_div;
   logic [32:0] w_add;
   logic [32:0] w_shift;
   logic        w_ge;
   logic [31:0] w_sub;
   logic [31:0] w_hi_nx;
   logic [31:0] w_lo_nx;
   logic [31:0] w_q;
   logic [31:0] w_r;
   logic [31:0] w_final;

   assign in_ready  = (r_state == S_IDLE) && !flush;
   assign w_accept  = in_valid && in_ready;
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign result    = r_result;
   assign rd_out    = r_rd;

   assign w_in_div = (op >= OP_DIV) && (op <= OP_REMU);
   assign w_in_sgn = (op == OP_DIV) || (op == OP_REM);
   assign w_abs1   = (w_in_sgn && src1[31]) ? (32'd0 - src1) : src1;
   assign w_abs2   = (w_in_sgn && src2[31]) ? (32'd0 - src2) : src2;

`ifdef MDU_EARLY_OUT_EN
   always_comb begin
      w_early     = 1'b0;
      w_early_res = 32'd0;
      if ((op == OP_MUL) || (op == OP_MULHU)) begin
         w_early = (src1 == 32'd0) || (src2 == 32'd0);
      end else if (w_in_div && (src2 == 32'd0)) begin
         w_early     = 1'b1;
         w_early_res = ((op == OP_REM) || (op == OP_REMU)) ? src1 : 32'hFFFF_FFFF;
      end
   end
`else
   assign w_early     = 1'b0;
   assign w_early_res = 32'd0;
`endif

   // Shared datapath: r_hi/r_lo hold the product halves or remainder/quotient.
   assign w_div   = (r_op >= OP_DIV) && (r_op <= OP_REMU);
   assign w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
   assign w_shift = {r_hi, r_lo[31]};
   assign w_ge    = (w_shift >= {1'b0, r_b});
   // True difference is always below 2^32 when w_ge, so 32-bit wrap is exact.
   assign w_sub   = w_shift[31:0] - r_b;

   always_comb begin
      w_hi_nx = r_hi;
      w_lo_nx = r_lo;
      if (w_div) begin
         w_hi_nx = w_ge ? w_sub : w_shift[31:0];
         w_lo_nx = {r_lo[30:0], w_ge};
      end else begin
         w_hi_nx = w_add[32:1];
         w_lo_nx = {w_add[0], r_lo[31:1]};
      end
   end

   assign w_q = r_neg_q ? (32'd0 - w_lo_nx) : w_lo_nx;
   assign w_r = r_neg_r ? (32'd0 - w_hi_nx) : w_hi_nx;

   always_comb begin
      w_final = 32'd0;
      case (r_op)
         OP_MUL:          w_final = w_lo_nx;
         OP_MULHU:        w_final = w_hi_nx;
         OP_DIV, OP_DIVU: w_final = r_dz ? 32'hFFFF_FFFF : w_q;
         OP_REM, OP_REMU: w_final = r_dz ? r_src1 : w_r;
         default:         w_final = 32'd0;
      endcase
   end

   always_comb begin
      w_state_nx = r_state;
      if (flush) begin
         w_state_nx = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (in_valid) w_state_nx = w_early ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == 5'd31) w_state_nx = S_DONE;
            S_DONE:  if (out_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op     <= 3'd0;
         r_src1   <= 32'd0;
         r_b      <= 32'd0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_cnt    <= 5'd0;
         r_rd     <= 5'd0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         r_result <= 32'd0;
      end else if (w_accept) begin
         r_op    <= op;
         r_src1  <= src1;
         r_rd    <= rd_in;
         r_cnt   <= 5'd0;
         r_hi    <= 32'd0;
         r_lo    <= w_abs1;
         r_b     <= w_abs2;
         r_neg_q <= w_in_sgn && (src1[31] ^ src2[31]);
         r_neg_r <= w_in_sgn && src1[31];
         r_dz    <= (src2 == 32'd0);
         if (w_early) begin
            r_result <= w_early_res;
         end
      end else if ((r_state == S_CALC) && !flush) begin
         r_hi  <= w_hi_nx;
         r_lo  <= w_lo_nx;
         r_cnt <= r_cnt + 5'd1;
         if (r_cnt == 5'd31) begin
            r_result <= w_final;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// tb_mdu_ctrl: directed plus randomized checks of mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [4:0]  rd_in;
   logic [4:0]  rd_out;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        flush;
   logic        busy;

   int total;
   int bad;

   mdu_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .src1      (src1),
      .src2      (src2),
      .rd_in     (rd_in),
      .rd_out    (rd_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flush     (flush),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0]        p;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic               ovf;
      p   = {32'd0, a} * {32'd0, b};
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (o)
         3'd0: return p[31:0];
         3'd1: return p[63:32];
         3'd2: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
         3'd3: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd4: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
         3'd5: return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
      if ((o <= 3'd1) && ((a == 0) || (b == 0))) return 1;
      if ((o >= 3'd2) && (o <= 3'd5) && (b == 0)) return 1;
`endif
      return 33;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // One request: accept, measure latency, check result, optionally stall the consumer.
   task automatic txn(input logic [2:0] t_op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input int hold);
      logic [31:0] er;
      int          el;
      int          lat;
      er = ref_res(t_op, a, b);
      el = ref_lat(t_op, a, b);
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      op        = t_op;
      src1      = a;
      src2      = b;
      rd_in     = rd;
      out_ready = (hold == 0);
      @(negedge clk);
      in_valid = 1'b0;
      op       = 3'($urandom_range(0, 7));
      src1     = $urandom;
      src2     = $urandom;
      rd_in    = 5'($urandom);
      lat      = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(el));
      chk("result", result, er);
      chk("rd_out", 32'(rd_out), 32'(rd));
      chk("busy_done", 32'(busy), 32'd1);
      if (hold > 0) begin
         in_valid = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", result, er);
            chk("hold_rd", 32'(rd_out), 32'(rd));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
         end
         out_ready = 1'b1;
      end
      @(negedge clk);
      chk("post_out_valid", 32'(out_valid), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      in_valid = 1'b0;
   endtask

   initial begin
      logic seen;
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      op        = 3'd0;
      src1      = 32'd0;
      src2      = 32'd0;
      rd_in     = 5'd0;
      out_ready = 1'b1;
      flush     = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rd_out", 32'(rd_out), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      txn(3'd0, 32'd7, 32'd6, 5'd17, 0);
      txn(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0);
      txn(3'd2, 32'hFFFF_FFF9, 32'd2, 5'd2, 0);
      txn(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 0);
      txn(3'd3, 32'd5, 32'd0, 5'd4, 0);
      txn(3'd5, 32'd5, 32'd0, 5'd5, 0);
      txn(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0);
      txn(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0);
      txn(3'd2, 32'hFFFF_FFFB, 32'd0, 5'd8, 0);
      txn(3'd4, 32'hFFFF_FFFB, 32'd0, 5'd9, 0);
      txn(3'd0, 32'd0, 32'd1234, 5'd10, 0);
      txn(3'd6, 32'd9, 32'd9, 5'd11, 0);
      txn(3'd0, 32'd3, 32'd4, 5'd12, 10);

      // Flush at iteration 15 with a competing request.
      @(negedge clk);
      in_valid = 1'b1; op = 3'd0; src1 = 32'd123; src2 = 32'd456; rd_in = 5'd3;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (15) @(negedge clk);
      chk("flush_busy_before", 32'(busy), 32'd1);
      flush = 1'b1; in_valid = 1'b1; op = 3'd2; src1 = 32'd100; src2 = 32'd7;
      #1;
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid || busy) seen = 1'b1;
      end
      chk("flush_no_output", 32'(seen), 32'd0);
      txn(3'd2, 32'd100, 32'd7, 5'd9, 0);

      // Asynchronous reset between edges while calculating.
      @(negedge clk);
      in_valid = 1'b1; op = 3'd3; src1 = 32'd1000; src2 = 32'd3; rd_in = 5'd5;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_result", result, 32'd0);
      chk("arst_rd_out", 32'(rd_out), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid || busy) seen = 1'b1;
      end
      chk("arst_no_stale", 32'(seen), 32'd0);

      for (int n = 0; n < 30; n++) begin
         txn(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
